// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shift-subtract step per clock,
// Run/Done handshake shared with the add-shift multiplier.
module restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  // The stored remainder is always below the divisor, so WIDTH bits suffice;
  // only the shifted trial value needs the extra bit.
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;
  logic             last_step;

  // NOTE: combinational logic uses blocking '=' with every output given a
  // value on every path, so no latch is inferred; state uses '<=' below.
  always_comb begin
    r_shift   = {r_reg, q_reg[WIDTH-1]};
    diff      = r_shift + ~{1'b0, d_reg} + 1'b1;
    q_step    = {q_reg[WIDTH-2:0], ~diff[WIDTH]};
    r_step    = diff[WIDTH] ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    last_step = (cnt == CW'(WIDTH - 1));
  end

  // NOTE: every register, including the datapath, is cleared by Reset so an
  // abandoned operation leaves no stale state behind.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Run) begin
            q_reg <= Dividend;
            d_reg <= Divisor;
            r_reg <= '0;
            cnt   <= '0;
            if (Divisor == '0) begin
              state     <= S_DONE;
              Done      <= 1'b1;
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
            end else begin
              state     <= S_CALC;
              Busy      <= 1'b1;
              DivByZero <= 1'b0;
            end
          end
        end

        S_CALC: begin
          q_reg <= q_step;
          r_reg <= r_step;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            state     <= S_DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Quotient  <= q_step;
            Remainder <= r_step;
          end
        end

        S_DONE: begin
          if (!Run) begin
            state <= S_IDLE;
            Done  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vector table, handshake
// and reset corner sequences, and a model-checked operand sweep.
module tb_restoring_divider;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Run;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         DivByZero;

  int errors = 0;
  int checks = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Raises Run with the given operands and waits (bounded) for Done.
  // lat counts rising edges from the Run edge up to the one that raised Done.
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int lat, output int busy_cnt, output bit ok);
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Run      = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (Busy) busy_cnt++;
      if (Done) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_run(input string tag);
    @(negedge Clk);
    Run = 1'b0;
    @(negedge Clk);
    check({tag, "_idle_done"}, 32'(Done), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit timing);
    int lat, busy_cnt;
    bit ok;
    start_and_wait(v.a, v.b, lat, busy_cnt, ok);
    if (ok) begin
      if (timing) begin
        check({tag, "_latency"}, 32'(lat), v.dbz ? 32'd1 : 32'd17);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), v.dbz ? 32'd0 : 32'd16);
      end
      check({tag, "_q"}, 32'(Quotient), 32'(v.q));
      check({tag, "_r"}, 32'(Remainder), 32'(v.r));
      check({tag, "_dbz"}, 32'(DivByZero), 32'(v.dbz));
    end
    release_run(tag);
  endtask

  vec_t vecs[13];

  initial begin
    vec_t v;
    int   lat, busy_cnt;
    bit   ok;

    vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0};
    vecs[1]  = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0};
    vecs[2]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0};
    vecs[3]  = '{16'd3,     16'd10,     16'd0,      16'd3,      1'b0};
    vecs[4]  = '{16'd5,     16'd0,      16'hFFFF,   16'd5,      1'b1};
    vecs[5]  = '{16'd9,     16'd3,      16'd3,      16'd0,      1'b0};
    vecs[6]  = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0};
    vecs[7]  = '{16'hFFFE,  16'hFFFF,   16'd0,      16'hFFFE,   1'b0};
    vecs[8]  = '{16'h8000,  16'd2,      16'h4000,   16'd0,      1'b0};
    vecs[9]  = '{16'h1234,  16'd0,      16'hFFFF,   16'h1234,   1'b1};
    vecs[10] = '{16'hFFFF,  16'h0100,   16'h00FF,   16'h00FF,   1'b0};
    vecs[11] = '{16'd12345, 16'd123,    16'd100,    16'd45,     1'b0};
    vecs[12] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,      1'b1};

    Reset    = 1'b1;
    Run      = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(negedge Clk);
    check("reset_q", 32'(Quotient), 32'd0);
    check("reset_r", 32'(Remainder), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_dbz", 32'(DivByZero), 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);

    // Run held high: one operation only, operand changes ignored while Done.
    start_and_wait(16'd50, 16'd6, lat, busy_cnt, ok);
    check("hold_latency", 32'(lat), 32'd17);
    @(negedge Clk);
    Dividend = 16'd9;
    Divisor  = 16'd2;
    for (int i = 0; i < 22; i++) begin
      @(negedge Clk);
      check("hold_done_high", 32'(Done), 32'd1);
      check("hold_no_busy", 32'(Busy), 32'd0);
    end
    check("hold_q", 32'(Quotient), 32'd8);
    check("hold_r", 32'(Remainder), 32'd2);
    release_run("hold");
    check("idle_keeps_q", 32'(Quotient), 32'd8);
    check("idle_keeps_r", 32'(Remainder), 32'd2);
    v = '{16'd9, 16'd2, 16'd4, 16'd1, 1'b0};
    run_vec(v, "restart", 1'b1);

    // Reset during CALC after eight steps abandons the operation.
    @(negedge Clk);
    Dividend = 16'd1000;
    Divisor  = 16'd3;
    Run      = 1'b1;
    @(negedge Clk);
    check("midcalc_busy", 32'(Busy), 32'd1);
    Run = 1'b0;
    repeat (8) @(negedge Clk);
    check("midcalc_still_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("midreset_q", 32'(Quotient), 32'd0);
    check("midreset_r", 32'(Remainder), 32'd0);
    check("midreset_busy", 32'(Busy), 32'd0);
    check("midreset_done", 32'(Done), 32'd0);
    check("midreset_dbz", 32'(DivByZero), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("post_reset_idle_busy", 32'(Busy), 32'd0);
    v = '{16'd1000, 16'd3, 16'd333, 16'd1, 1'b0};
    run_vec(v, "after_reset", 1'b1);

    // Reset while in DONE clears the outputs too.
    start_and_wait(16'd77, 16'd0, lat, busy_cnt, ok);
    check("pre_done_reset_dbz", 32'(DivByZero), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("done_reset_done", 32'(Done), 32'd0);
    check("done_reset_q", 32'(Quotient), 32'd0);
    check("done_reset_dbz", 32'(DivByZero), 32'd0);
    Reset = 1'b0;
    Run   = 1'b0;
    @(negedge Clk);

    // Operand sweep against the arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      int unsigned sel;
      v.a = W'($urandom_range(0, 65535));
      sel = $urandom_range(0, 9);
      if (sel == 0)      v.b = '0;
      else if (sel < 4)  v.b = W'($urandom_range(1, 15));
      else               v.b = W'($urandom_range(1, 65535));
      if (v.b == '0) begin
        v.q   = '1;
        v.r   = v.a;
        v.dbz = 1'b1;
      end else begin
        v.q   = v.a / v.b;
        v.r   = v.a % v.b;
        v.dbz = 1'b0;
      end
      run_vec(v, $sformatf("sweep%0d", i), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
